// File: rtl/imm_pack_pkg.sv
// Shared definitions for the immediate packer: extender op codes, FSM encoding
// and the classifier result payload.
package imm_pack_pkg;

    localparam int unsigned VAL_W = 32;
    localparam int unsigned IMM_W = 16;
    localparam int unsigned EOP_W = 2;

    localparam logic [EOP_W-1:0] EOP_SIGN = 2'b00;
    localparam logic [EOP_W-1:0] EOP_ZERO = 2'b01;
    localparam logic [EOP_W-1:0] EOP_LUI  = 2'b10;
    localparam logic [EOP_W-1:0] EOP_BR   = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND_HI = 2'd1;
    localparam logic [1:0] ST_SEND_LO = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        SEND_HI = ST_SEND_HI,
        SEND_LO = ST_SEND_LO
    } state_t;

    typedef struct packed {
        logic [EOP_W-1:0] eop;
        logic [IMM_W-1:0] imm;
        logic             two_beat;
        logic [IMM_W-1:0] lo_imm;
        logic             err;
    } class_t;

endpackage

// File: rtl/imm_pack_classify.sv
// Combinational classifier: picks the cheapest extender encoding for a value,
// or the branch encoding with an encodability flag.
module imm_classify
    import imm_pack_pkg::*;
(
    input  logic [VAL_W-1:0] value,
    input  logic             mode,
    output class_t           res
);

    always_comb begin
        res        = '0;
        res.eop    = EOP_SIGN;
        res.imm    = value[15:0];
        res.lo_imm = value[15:0];
        if (mode) begin
            res.eop = EOP_BR;
            res.imm = value[17:2];
            res.err = (value[1:0] != 2'b00) ||
                      !((value[31:17] == '0) || (value[31:17] == '1));
        end else if ((value[31:15] == '0) || (value[31:15] == '1)) begin
            res.eop = EOP_SIGN;
        end else if (value[31:16] == '0) begin
            res.eop = EOP_ZERO;
        end else if (value[15:0] == '0) begin
            res.eop = EOP_LUI;
            res.imm = value[31:16];
        end else begin
            // lui of the high half first; the low half follows as a zero-extended ori
            res.eop      = EOP_LUI;
            res.imm      = value[31:16];
            res.two_beat = 1'b1;
        end
    end

endmodule

// File: rtl/imm_pack.sv
// Immediate packer: splits a constant or branch offset into one or two
// (imm16, EOp) beats behind a registered valid/ready output stage.
module imm_pack
    import imm_pack_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_value,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IMM_W-1:0] out_imm,
    output logic [EOP_W-1:0] out_eop,
    output logic             out_last,
    output logic             out_err
);

    state_t           state;
    logic [IMM_W-1:0] lo_imm;
    class_t           cls;
    logic             accept;

    imm_classify u_classify (
        .value (in_value),
        .mode  (in_mode),
        .res   (cls)
    );

    // A new request may enter when idle or as the final beat leaves
    assign in_ready = (state == IDLE) || (out_valid && out_ready && out_last);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_eop   <= EOP_SIGN;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            lo_imm    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_imm   <= cls.imm;
            out_eop   <= cls.eop;
            out_last  <= !cls.two_beat;
            out_err   <= cls.err;
            lo_imm    <= cls.lo_imm;
            state     <= cls.two_beat ? SEND_HI : SEND_LO;
        end else begin
            // SEND_LO presents any last beat, single or second of two
            case (state)
                SEND_HI: begin
                    if (out_ready) begin
                        out_imm  <= lo_imm;
                        out_eop  <= EOP_ZERO;
                        out_last <= 1'b1;
                        out_err  <= 1'b0;
                        state    <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_pack.sv
// Scoreboard bench for imm_pack: directed requests push hand-computed beats,
// a negedge monitor pops and compares every beat the DUT hands over.
module tb_imm_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic        out_err;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic        last;
        logic        err;
        logic        chk;
        logic [31:0] val;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    imm_pack dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_eop   (out_eop),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ext(input logic [1:0] eop, input logic [15:0] imm);
        case (eop)
            2'b00:   ext = {{16{imm[15]}}, imm};
            2'b01:   ext = {16'h0000, imm};
            2'b10:   ext = {imm, 16'h0000};
            default: ext = {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop on each handshake, verify hold while stalled, rebuild split values
    logic [31:0] acc = '0;
    logic        prev_hold = 1'b0;
    logic [20:0] prev_beat;

    always @(negedge clk) begin
        beat_t e;
        logic [31:0] x;
        if (reset) begin
            prev_hold = 1'b0;
            acc       = '0;
        end else begin
            if (prev_hold)
                check("hold_stable", {11'd0, out_valid, out_imm, out_eop, out_last, out_err},
                      {11'd0, 1'b1, prev_beat[19:0]});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got imm=%h eop=%b, expected none", out_imm, out_eop);
                end else begin
                    e = sb.pop_front();
                    check("beat", {11'd0, out_imm, out_eop, out_last, out_err},
                          {11'd0, e.imm, e.eop, e.last, e.err});
                    x = acc | ext(out_eop, out_imm);
                    if (out_last) begin
                        if (e.chk) check("reconstruct", x, e.val);
                        acc = '0;
                    end else begin
                        acc = x;
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_beat = {1'b1, out_imm, out_eop, out_last, out_err};
        end
    end

    function automatic beat_t mk(input logic [15:0] imm, input logic [1:0] eop,
                                 input logic last, input logic err,
                                 input logic chk, input logic [31:0] val);
        beat_t b;
        b.imm = imm; b.eop = eop; b.last = last; b.err = err; b.chk = chk; b.val = val;
        return b;
    endfunction

    // Present a request until accepted; leaves in_valid asserted for back-to-back use
    task automatic send(input logic [31:0] v, input logic m, input beat_t b0,
                        input logic two, input beat_t b1, input logic want_ready_now);
        int n = 0;
        in_valid = 1'b1;
        in_value = v;
        in_mode  = m;
        @(negedge clk);
        if (want_ready_now) check("in_ready_now", {31'd0, in_ready}, 32'd1);
        while (!in_ready) begin
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
                break;
            end
            @(negedge clk);
        end
        if (in_ready) begin
            sb.push_back(b0);
            if (two) sb.push_back(b1);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain", {31'd0, sb.size() == 0 && !out_valid}, 32'd1);
    endtask

    beat_t none;

    initial begin
        none      = mk(16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_state", {26'd0, out_valid, out_imm[0], out_eop, out_last, out_err},
              32'd0);
        check("reset_imm", {16'd0, out_imm}, 32'd0);
        check("reset_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a two-beat split discards the low half
        @(posedge clk); #2;
        send(32'h12345678, 1'b0, mk(16'h1234, 2'b10, 1'b0, 1'b0, 1'b0, 0), 1'b1,
             mk(16'h5678, 2'b01, 1'b1, 1'b0, 1'b1, 32'h12345678), 1'b1);
        in_valid = 1'b0;
        reset    = 1'b1;
        sb.delete();
        @(posedge clk); #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_lo_beat", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #2;

        // Back-to-back single-beat constants
        send(32'hFFFFFFFC, 1'b0, mk(16'hFFFC, 2'b00, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFC), 1'b0, none, 1'b1);
        send(32'h0000ABCD, 1'b0, mk(16'hABCD, 2'b01, 1'b1, 1'b0, 1'b1, 32'h0000ABCD), 1'b0, none, 1'b1);
        send(32'h7FFF0000, 1'b0, mk(16'h7FFF, 2'b10, 1'b1, 1'b0, 1'b1, 32'h7FFF0000), 1'b0, none, 1'b1);
        drain();

        // Two-beat constant, in_ready low while the high half is presented
        send(32'h12345678, 1'b0, mk(16'h1234, 2'b10, 1'b0, 1'b0, 1'b0, 0), 1'b1,
             mk(16'h5678, 2'b01, 1'b1, 1'b0, 1'b1, 32'h12345678), 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("two_beat_ready_low", {30'd0, in_ready, out_valid}, 32'd1);
        drain();

        // Backpressure on the first beat of a split
        out_ready = 1'b0;
        send(32'hDEADBEEF, 1'b0, mk(16'hDEAD, 2'b10, 1'b0, 1'b0, 1'b0, 0), 1'b1,
             mk(16'hBEEF, 2'b01, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF), 1'b1);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_held", {13'd0, out_valid, out_imm, out_eop, out_last}, {13'd0, 1'b1, 16'hDEAD, 2'b10, 1'b0});
        end
        @(posedge clk); #2;
        drain();

        // Branch offsets
        out_ready = 1'b1;
        send(32'hFFFFFFF8, 1'b1, mk(16'hFFFE, 2'b11, 1'b1, 1'b0, 1'b1, 32'hFFFFFFF8), 1'b0, none, 1'b1);
        send(32'h00020000, 1'b1, mk(16'h8000, 2'b11, 1'b1, 1'b1, 1'b0, 0), 1'b0, none, 1'b1);
        send(32'h00000006, 1'b1, mk(16'h0001, 2'b11, 1'b1, 1'b1, 1'b0, 0), 1'b0, none, 1'b1);

        // Classification boundaries
        send(32'h00008000, 1'b0, mk(16'h8000, 2'b01, 1'b1, 1'b0, 1'b1, 32'h00008000), 1'b0, none, 1'b1);
        send(32'hFFFF8000, 1'b0, mk(16'h8000, 2'b00, 1'b1, 1'b0, 1'b1, 32'hFFFF8000), 1'b0, none, 1'b1);
        send(32'h00000000, 1'b0, mk(16'h0000, 2'b00, 1'b1, 1'b0, 1'b1, 32'h00000000), 1'b0, none, 1'b1);
        send(32'hFFFF0000, 1'b0, mk(16'hFFFF, 2'b10, 1'b1, 1'b0, 1'b1, 32'hFFFF0000), 1'b0, none, 1'b1);
        drain();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_pack.md
Name: imm_pack

Overview:
- Inverse of the immediate extender: takes a 32-bit constant or branch byte offset and emits one or two (imm16, EOp) beats.
- Applying the extender to each beat reproduces the value. For a two-beat split, OR the extended beats (lui+ori).
- Sits in the assembler/instruction-generation path that feeds the instruction ROM builder and test-program generators.
- Registered output stage with valid/ready handshakes on both sides.

Parameters:
- none; widths are fixed by the ISA: 32-bit value, 16-bit imm, 2-bit EOp.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted this cycle when high together with in_valid
- in_value  in  32  constant, or branch byte offset
- in_mode  in  1  0 = constant, 1 = branch offset
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_imm  out  16  immediate field
- out_eop  out  2  extender op: 00 sign, 01 zero, 10 lui, 11 sign+shift2
- out_last  out  1  final beat of this request
- out_err  out  1  branch offset not encodable (valid only with out_valid)

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE; out_valid=0, out_imm=0, out_eop=00, out_last=0, out_err=0.
  - Any pending second beat is discarded, including mid-request.
- FSM states: IDLE, SEND_HI, SEND_LO.
  - in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
  - Back-to-back single-beat requests therefore sustain 1 per cycle.
- Accept at edge t: beat registered, out_valid=1 from t+1 (latency 1).
- Constant-mode classification, first match wins:
  - in_value[31:15] all equal -> EOp 00, imm=in_value[15:0], last=1.
  - in_value[31:16]==0 -> EOp 01, imm=in_value[15:0], last=1.
  - in_value[15:0]==0 -> EOp 10, imm=in_value[31:16], last=1.
  - Otherwise two beats. State SEND_HI: EOp 10, imm=in_value[31:16], last=0. Then SEND_LO: EOp 01, imm=in_value[15:0], last=1. The low half is held in an internal register.
- Branch mode:
  - Single beat: EOp 11, imm=in_value[17:2], last=1.
  - out_err=1 if in_value[1:0]!=0 or in_value[31:17] not all equal. The beat is still emitted with the truncated field.
- out_err=0 in constant mode.
- Handshake rules:
  - While out_valid & !out_ready, all out_* hold stable.
  - SEND_HI -> SEND_LO only on out_ready.
  - SEND_LO or a last beat -> IDLE on out_ready, unless a new request is accepted in the same cycle. In that case load the new beat directly (no bubble).
- Edge cases:
  - in_valid while in_ready=0 is ignored; the sender holds.
  - in_value=0 -> EOp 00, imm 0000.
  - 0x00008000 -> EOp 01 (fails the sign check).
  - 0xFFFF8000 -> EOp 00.

Decomposition:
- Shared package holds:
  - EOP_SIGN=2'b00, EOP_ZERO=2'b01, EOP_LUI=2'b10, EOP_BR=2'b11; reuse these in the extender.
  - State encoding localparams for IDLE/SEND_HI/SEND_LO.
- One combinational sub-module, imm_classify: (value, mode) -> {eop, imm, two_beat, lo_imm, err}.
- imm_pack owns the FSM, registers and handshake.

Test Plan:
- Reset mid two-beat:
  - Stimulus: 0x12345678 accepted, reset asserted during SEND_HI.
  - Expected: next cycle out_valid=0, in_ready=1; no SEND_LO beat appears after reset.
- Single-beat constants, out_ready=1, back-to-back:
  - Stimulus: 0xFFFFFFFC, 0x0000ABCD, 0x7FFF0000.
  - Expected: (FFFC,00,last) (ABCD,01,last) (7FFF,10,last) on consecutive cycles; in_ready never drops.
- Two-beat constant:
  - Stimulus: 0x12345678.
  - Expected: (1234,10,last=0) then (5678,01,last=1). in_ready=0 during the first beat; extend+OR reconstructs 0x12345678.
- Backpressure:
  - Stimulus: 0xDEADBEEF with out_ready=0 for 3 cycles.
  - Expected: (DEAD,10,0) held stable 3 cycles, then (BEEF,01,1).
- Branch mode:
  - 0xFFFFFFF8 -> (FFFE,11,err=0).
  - 0x00020000 -> err=1, imm 8000.
  - 0x00000006 -> err=1.
- Boundaries:
  - 0x00008000 -> 01/8000.
  - 0xFFFF8000 -> 00/8000.
  - 0x00000000 -> 00/0000.
  - 0xFFFF0000 -> 10/FFFF.
